// File: rtl/lsu_seq.sv
// lsu_seq: multi-cycle load/store sequencer between the RV32 datapath and a req/ack data bus.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses in two; otherwise they are rejected via o_misalign.
module lsu_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [1:0]  i_mem_op,
    input  logic [1:0]  i_data_type,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] DT_BYTE  = 2'b10;
    localparam logic [1:0] DT_HALF  = 2'b01;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;

    logic        r_is_load;
    logic [1:0]  r_type;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_misalign;
    logic [31:0] r_buf0;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;

    logic [1:0]  w_in_off;
    logic [3:0]  w_in_mask;
    logic        w_in_noop;
    logic        w_in_mis;
    logic        w_in_bus;
    logic [3:0]  w_in_be_lo;
    logic [31:0] w_in_wd_lo;
    logic        w_accept;
    logic        w_ack;
    logic [31:0] w_load_word;
    logic        w_done;

    function automatic logic [31:0] f_lanes(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    assign w_in_off  = i_addr[1:0];
    assign w_in_noop = (i_mem_op == 2'b00) || (i_mem_op == 2'b11);
    assign w_accept  = (r_state == IDLE) && i_req;
    assign w_ack     = r_bus_req && i_bus_ack;

    always_comb begin
        w_in_mask = 4'b1111;
        case (i_data_type)
            DT_BYTE: w_in_mask = 4'b0001;
            DT_HALF: w_in_mask = 4'b0011;
            default: w_in_mask = 4'b1111;
        endcase
    end

    // The size mask shifted by the byte offset gives both the byte enables and the data lanes.
    assign w_in_be_lo = 4'({4'b0000, w_in_mask} << w_in_off);
    assign w_in_wd_lo = (i_wdata << {w_in_off, 3'b000}) & f_lanes(w_in_be_lo);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        r_split;
    logic [3:0]  r_be_hi;
    logic [31:0] r_wd_hi;
    logic [31:0] r_buf1;
    logic [3:0]  w_in_be_hi;
    logic [31:0] w_in_wd_hi;

    assign w_in_be_hi  = 4'(({4'b0000, w_in_mask} << w_in_off) >> 4);
    assign w_in_wd_hi  = 32'(({32'd0, i_wdata} << {w_in_off, 3'b000}) >> 32) & f_lanes(w_in_be_hi);
    assign w_in_mis    = 1'b0;
    assign w_load_word = 32'({r_buf1, r_buf0} >> {r_off, 3'b000});
`else
    assign w_in_mis    = ~w_in_noop &
                         (((i_data_type == DT_HALF) && i_addr[0]) ||
                          ((i_data_type != DT_BYTE) && (i_data_type != DT_HALF) && (w_in_off != 2'b00)));
    assign w_load_word = r_buf0 >> {r_off, 3'b000};
`endif

    assign w_in_bus = ~w_in_noop & ~w_in_mis;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_next_state = w_in_bus ? ACC0 : DONE;
                end
            end
            ACC0: begin
                if (w_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    w_next_state = r_split ? ACC1 : DONE;
`else
                    w_next_state = DONE;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                if (w_ack) begin
                    w_next_state = DONE;
                end
            end
`endif
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_done     = (r_state == DONE);
        o_misalign = w_done & r_misalign;
        o_rdata    = 32'd0;
        if (w_done && r_is_load && !r_misalign) begin
            case (r_type)
                DT_BYTE: o_rdata = {{24{~r_unsigned & w_load_word[7]}}, w_load_word[7:0]};
                DT_HALF: o_rdata = {{16{~r_unsigned & w_load_word[15]}}, w_load_word[15:0]};
                default: o_rdata = w_load_word;
            endcase
        end
    end

    assign o_done  = w_done;
    assign o_stall = i_req & ~w_done;

    // Request attributes are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_load  <= 1'b0;
            r_type     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_misalign <= 1'b0;
            r_buf0     <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split    <= 1'b0;
            r_be_hi    <= 4'd0;
            r_wd_hi    <= 32'd0;
            r_buf1     <= 32'd0;
`endif
        end else begin
            if (w_accept) begin
                r_is_load  <= (i_mem_op == OP_LOAD);
                r_type     <= i_data_type;
                r_unsigned <= i_unsigned;
                r_off      <= w_in_off;
                r_misalign <= w_in_mis;
`ifdef LSU_MISALIGN_SPLIT_EN
                r_split    <= |w_in_be_hi;
                r_be_hi    <= w_in_be_hi;
                r_wd_hi    <= w_in_wd_hi;
`endif
            end
            if ((r_state == ACC0) && w_ack) begin
                r_buf0 <= i_bus_rdata;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((r_state == ACC1) && w_ack) begin
                r_buf1 <= i_bus_rdata;
            end
`endif
        end
    end

    // Bus outputs are registered and only move on acceptance or on a sampled ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req && w_in_bus) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= (i_mem_op == OP_STORE);
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_wdata <= w_in_wd_lo;
                        r_bus_be    <= w_in_be_lo;
                    end
                end
                ACC0: begin
                    if (w_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (r_split) begin
                            r_bus_addr  <= r_bus_addr + 32'd4;
                            r_bus_wdata <= r_wd_hi;
                            r_bus_be    <= r_be_hi;
                        end else begin
                            r_bus_req   <= 1'b0;
                            r_bus_we    <= 1'b0;
                            r_bus_addr  <= 32'd0;
                            r_bus_wdata <= 32'd0;
                            r_bus_be    <= 4'd0;
                        end
`else
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= 32'd0;
                        r_bus_wdata <= 32'd0;
                        r_bus_be    <= 4'd0;
`endif
                    end
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1: begin
                    if (w_ack) begin
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= 32'd0;
                        r_bus_wdata <= 32'd0;
                        r_bus_be    <= 4'd0;
                    end
                end
`endif
                default: begin
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed and randomized accesses against a byte-level model of lsu_seq.
// Honours LSU_MISALIGN_SPLIT_EN the same way as the design build.
module tb_lsu_seq;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic [1:0]  i_mem_op;
    logic [1:0]  i_data_type;
    logic        i_unsigned;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_misalign;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int vecCount  = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    lsu_seq dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_mem_op    (i_mem_op),
        .i_data_type (i_data_type),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_misalign  (o_misalign),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_be    (o_bus_be),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (be[j]) m[8*j +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // One access end to end: the model works byte by byte over the words the access touches.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] dt, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rd0, input logic [31:0] rd1,
                                 input int wait0, input int wait1);
        int          size, off, nTxn, txn, waitCnt, cycles, expCycles, pos, k, lane;
        bit          isLoad, noop, mis, gotDone;
        logic [31:0] expAddr [2];
        logic [3:0]  expBe [2];
        logic [31:0] expWd [2];
        logic [31:0] words [2];
        int          waits [2];
        logic [31:0] expRdata;

        size   = (dt == 2'b10) ? 1 : (dt == 2'b01) ? 2 : 4;
        off    = int'(addr[1:0]);
        noop   = (op == 2'b00) || (op == 2'b11);
        isLoad = (op == 2'b10);
`ifdef LSU_MISALIGN_SPLIT_EN
        mis = 1'b0;
`else
        mis = !noop && ((off % size) != 0);
`endif
        nTxn     = (noop || mis) ? 0 : ((off + size - 1) / 4 + 1);
        words[0] = rd0;
        words[1] = rd1;
        waits[0] = wait0;
        waits[1] = wait1;
        expRdata = 32'd0;
        for (int t = 0; t < 2; t++) begin
            expAddr[t] = (addr - 32'(off)) + 32'(4 * t);
            expBe[t]   = 4'd0;
            expWd[t]   = 32'd0;
        end
        for (int i = 0; i < size; i++) begin
            pos  = off + i;
            k    = pos / 4;
            lane = pos % 4;
            expBe[k][lane]         = 1'b1;
            expWd[k][8*lane +: 8]  = wdata[8*i +: 8];
            expRdata[8*i +: 8]     = words[k][8*lane +: 8];
        end
        if (isLoad && size < 4 && !uns && expRdata[8*size-1]) begin
            for (int i = size; i < 4; i++) expRdata[8*i +: 8] = 8'hFF;
        end
        if (!isLoad || mis) expRdata = 32'd0;
        expCycles = 1;
        for (int t = 0; t < nTxn; t++) expCycles += 1 + waits[t];

        @(negedge clk);
        i_req       = 1'b1;
        i_mem_op    = op;
        i_data_type = dt;
        i_unsigned  = uns;
        i_addr      = addr;
        i_wdata     = wdata;
        i_bus_ack   = 1'($urandom);
        i_bus_rdata = $urandom;
        txn = 0; waitCnt = 0; cycles = 0; gotDone = 1'b0;

        for (int c = 0; c < 40 && !gotDone; c++) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                i_mem_op    = 2'($urandom);
                i_data_type = 2'($urandom);
                i_unsigned  = 1'($urandom);
                i_addr      = $urandom;
                i_wdata     = $urandom;
            end
            if (o_done) begin
                gotDone = 1'b1;
                checkOutput("txn_count", 32'(txn), 32'(nTxn));
                checkOutput("latency", 32'(cycles), 32'(expCycles));
                checkOutput("rdata", o_rdata, expRdata);
                checkOutput("misalign", 32'(o_misalign), 32'(mis));
                checkOutput("stall_at_done", 32'(o_stall), 32'd0);
                checkOutput("bus_req_at_done", 32'(o_bus_req), 32'd0);
                i_req     = 1'b0;
                i_bus_ack = 1'b0;
            end else begin
                checkOutput("stall", 32'(o_stall), 32'd1);
                if (txn < nTxn) begin
                    checkOutput("bus_req", 32'(o_bus_req), 32'd1);
                    checkOutput("bus_addr", o_bus_addr, expAddr[txn]);
                    checkOutput("bus_be", 32'(o_bus_be), 32'(expBe[txn]));
                    checkOutput("bus_we", 32'(o_bus_we), 32'(!isLoad));
                    if (!isLoad) checkOutput("bus_wdata", o_bus_wdata & laneMask(expBe[txn]), expWd[txn]);
                    if (waitCnt == waits[txn]) begin
                        i_bus_ack   = 1'b1;
                        i_bus_rdata = words[txn];
                        txn++;
                        waitCnt = 0;
                    end else begin
                        i_bus_ack   = 1'b0;
                        i_bus_rdata = $urandom;
                        waitCnt++;
                    end
                end else begin
                    checkOutput("done_expected", 32'(o_done), 32'd1);
                    i_bus_ack = 1'b1;
                end
            end
        end
        checkOutput("done_seen", 32'(gotDone), 32'd1);
        i_req     = 1'b0;
        i_bus_ack = 1'b0;
    endtask

    initial begin
        logic [1:0]  rOp, rDt;
        logic [31:0] rAddr;
        logic [1:0]  dtTable [3];
        dtTable[0] = 2'b00; dtTable[1] = 2'b01; dtTable[2] = 2'b10;

        i_rst_n = 1'b0; i_req = 1'b0; i_mem_op = 2'b00; i_data_type = 2'b00; i_unsigned = 1'b0;
        i_addr = 32'd0; i_wdata = 32'd0; i_bus_ack = 1'b0; i_bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_done", 32'(o_done), 32'd0);
        checkOutput("reset_stall", 32'(o_stall), 32'd0);
        checkOutput("reset_rdata", o_rdata, 32'd0);
        checkOutput("reset_misalign", 32'(o_misalign), 32'd0);
        checkOutput("reset_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("reset_bus_addr", o_bus_addr, 32'd0);
        checkOutput("reset_bus_be", 32'(o_bus_be), 32'd0);
        i_rst_n = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(2'b01, 2'b00, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 32'd0, 0, 0);
        applyStimulus(2'b10, 2'b10, 1'b0, 32'h0000_0203, 32'd0, 32'h80FF_FFFF, 32'd0, 0, 0);
        applyStimulus(2'b10, 2'b10, 1'b1, 32'h0000_0203, 32'd0, 32'h80FF_FFFF, 32'd0, 0, 0);
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h0000_0102, 32'd0, 32'h4433_2211, 32'h8877_6655, 2, 2);
        applyStimulus(2'b01, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_ABCD, 32'd0, 32'd0, 1, 0);
        applyStimulus(2'b10, 2'b01, 1'b0, 32'h0000_0012, 32'd0, 32'h9876_0000, 32'd0, 0, 0);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'd0, 32'd0, 0, 0);
        applyStimulus(2'b11, 2'b10, 1'b0, 32'h0000_0041, 32'h1234_5678, 32'd0, 32'd0, 0, 0);
        applyStimulus(2'b10, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'hCAFE_F00D, 32'h1122_3344, 0, 1);

        $display("[TB] reset during bus wait");
        @(negedge clk);
        i_req = 1'b1; i_mem_op = 2'b10; i_data_type = 2'b00; i_addr = 32'h0000_0040; i_bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_bus_req", 32'(o_bus_req), 32'd1);
        #1;
        i_rst_n = 1'b0;
        i_req   = 1'b0;
        #1;
        checkOutput("abort_bus_req", 32'(o_bus_req), 32'd0);
        checkOutput("abort_bus_addr", o_bus_addr, 32'd0);
        checkOutput("abort_bus_be", 32'(o_bus_be), 32'd0);
        checkOutput("abort_done", 32'(o_done), 32'd0);
        checkOutput("abort_stall", 32'(o_stall), 32'd0);
        checkOutput("abort_rdata", o_rdata, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("no_resume_bus_req", 32'(o_bus_req), 32'd0);
        applyStimulus(2'b10, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 32'h0BAD_CAFE, 32'd0, 1, 0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 80; n++) begin
            rOp   = 2'($urandom_range(0, 3));
            rDt   = dtTable[$urandom_range(0, 2)];
            rAddr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            applyStimulus(rOp, rDt, 1'($urandom), rAddr, $urandom, $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Multi-cycle load/store sequencer between the core datapath and the data-memory bus. It accepts one load or store per request from the execute stage, using the control unit's mem_wren/i_data_type/i_unsigned encodings. It drives a req/ack bus with word-aligned addresses and byte enables, and stalls the core until the access completes. With the split feature enabled, it splits word-boundary-crossing accesses into two bus transactions.

## Interface
- No parameters; widths fixed for RV32.
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  datapath access request; held high until o_done.
- i_mem_op  in  2  2'b10 load, 2'b01 store; 00/11 = no-op.
- i_data_type  in  2  2'b10 byte, 2'b01 half, 2'b00 word.
- i_unsigned  in  1  zero-extend loads when 1.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-justified.
- o_stall  out  1  freeze PC/pipeline.
- o_done  out  1  one-cycle completion pulse; o_rdata valid in this cycle.
- o_rdata  out  32  extended load data; 0 for stores.
- o_misalign  out  1  with o_done: access was misaligned and not performed.
- o_bus_req  out  1  bus transaction valid.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word-aligned address, bits [1:0] = 0.
- o_bus_wdata  out  32  lane-positioned write data.
- o_bus_be  out  4  byte enables.
- i_bus_ack  in  1  transaction complete; sampled while o_bus_req = 1.
- i_bus_rdata  in  32  read word; valid with i_bus_ack.

## Operation
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE
  - With i_req = 1, latch op, type, unsigned, addr and wdata, then go to ACC0.
  - A no-op (i_mem_op 00/11) goes directly to DONE with no bus activity.
- ACC0
  - Drive o_bus_req with addr & ~3.
  - On ack: go to ACC1 if split is needed, else DONE.
- ACC1
  - Drive o_bus_req with (addr & ~3) + 4; wraps modulo 2^32 at 0xFFFFFFFC.
  - On ack: go to DONE.
- DONE
  - Pulse o_done and return to IDLE.
- Offset: off = addr[1:0]. Access size: byte 1, half 2, word 4.
- Split needed when off + size > 4: half at off 3, word at off 1/2/3.
- Byte enables: 8-bit mask ((1<<size)-1) << off.
  - ACC0 uses mask[3:0]; ACC1 uses mask[7:4].
  - The same mask, shifted by off*8, positions the write data lanes.
- Stores: o_bus_we = 1, o_rdata = 0.
- Loads
  - Each ack stores i_bus_rdata into buffer word 0 or 1.
  - Result = {w1, w0} >> (off*8), truncated to size.
  - Byte/half results are sign-extended, or zero-extended when i_unsigned = 1; words are unextended.
- o_stall = i_req & ~o_done, combinational.

## Timing
- Reset value of every output, FSM state and data register is 0; the FSM resets to IDLE.
- Reset mid-transaction aborts immediately: o_bus_req drops asynchronously and the access is never resumed.
- o_bus_req and bus outputs are registered.
  - They first go high the cycle after acceptance.
  - They are held stable until the cycle in which i_bus_ack = 1 is sampled.
- Aligned access with immediate ack: accept at edge N; bus request during N+1; o_done high during N+2.
- Split access with immediate acks: o_done high during N+3.
- Each ack wait cycle adds one cycle.
- i_bus_ack while o_bus_req = 0 is ignored.
- o_done is high for exactly one cycle. i_req may be high again in the cycle after o_done and is then accepted as a new request.
- Inputs are sampled only at acceptance; changes during the stall have no effect.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses are split as described; o_misalign is tied to 0.
- LSU_MISALIGN_SPLIT_EN undefined:
  - ACC1 is removed.
  - Any access with a misaligned address (half with addr[0] = 1; word with addr[1:0] ≠ 0) issues no bus transaction. It goes IDLE→DONE with o_done = 1, o_misalign = 1 and o_rdata = 0.

## Test plan
- Aligned word store 0xDEADBEEF to 0x100, ack immediate → one bus write: addr 0x100, be 4'b1111, wdata 0xDEADBEEF; o_done two cycles after accept.
- Signed byte load from 0x203, bus returns 0x80FFFFFF → be 4'b1000; o_rdata 0xFFFFFF80. Same access with i_unsigned = 1 → o_rdata 0x00000080.
- Word load at 0x102 (split), bus returns 0x44332211 then 0x88776655 with 2 wait cycles each:
  - Two transactions: 0x100 with be 1100, then 0x104 with be 0011.
  - o_rdata 0x66554433; o_stall high until o_done.
- Half store 0xABCD at 0x3 → be 1000 with wdata[31:24] = 0xCD, then 0x4 with be 0001 and wdata[7:0] = 0xAB. Without the macro: no bus request, o_misalign = 1 with o_done.
- Assert i_rst_n = 0 while waiting for ack in ACC0 → all outputs 0 immediately. After release, a new aligned load completes normally.
- No-op (i_mem_op = 2'b00) with i_req → o_done the next cycle, no o_bus_req, o_rdata 0.
